// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: turns UART receiver level flags into byte pushes and error
// events, buffering bytes in a first-word-fall-through FIFO.
//
// Ports:
//   clk50m    system clock, rising edge
//   rst       synchronous reset, active-high (priority over clear)
//   rx_data   received byte, valid while rx_ready is high
//   rx_ready  receiver "byte done" level flag (rising edge = push)
//   rx_error  receiver "framing error" level flag (rising edge = error)
//   clear     synchronous flush of FIFO and statistics
//   m_data    head-of-FIFO byte, meaningful while m_valid
//   m_valid   FIFO not empty
//   m_ready   consumer takes m_data this cycle
//   level     number of stored bytes, 0..DEPTH
//   full      level == DEPTH
//   overflow  sticky: a byte was dropped because the FIFO was full
//   err_cnt   saturating count of framing errors
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int ERR_W = 8
) (
    input  logic                   clk50m,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    input  logic                   rx_error,
    input  logic                   clear,
    output logic [7:0]             m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   overflow,
    output logic [ERR_W-1:0]       err_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];

    logic rdy_q;
    logic err_q;
    logic push;
    logic err_ev;
    logic pop;
    logic wr_en;
    logic flush;

    // Reset forces the history high so a flag already asserted when
    // reset releases is not mistaken for a fresh edge. clear leaves the
    // history sampling so it cannot manufacture an event either.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            rdy_q <= 1'b1;
            err_q <= 1'b1;
        end else begin
            rdy_q <= rx_ready;
            err_q <= rx_error;
        end
    end

    assign push   = rx_ready & ~rdy_q;
    assign err_ev = rx_error & ~err_q;
    assign flush  = rst | clear;

    // Extra pointer bit distinguishes full from empty.
    assign m_valid = (wr_ptr != rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign level   = wr_ptr - rd_ptr;
    assign m_data  = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign pop   = m_valid & m_ready;
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk50m) begin
        if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push & ~wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk50m) begin
        if (~flush & wr_en) begin
            mem[wr_ptr[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk50m) begin
        if (flush) begin
            err_cnt <= '0;
        end else if (err_ev && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed checks of uart_rx_fifo against
// a queue-based reference model of the receive buffer.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int ERR_W = 8;

    logic       clk50m = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       rx_error = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [4:0] level;
    logic       full;
    logic       overflow;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         m_ovf;
    int         m_err;
    bit         p_r;
    bit         p_e;

    uart_rx_fifo #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk50m   (clk50m),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_error (rx_error),
        .clear    (clear),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .full     (full),
        .overflow (overflow),
        .err_cnt  (err_cnt)
    );

    always #10 clk50m = ~clk50m;

    // Drive one cycle of inputs (called at a negedge), advance the model
    // by the spec rules, and return at the next negedge. On a pop, the
    // byte the DUT presents and the byte the model expects are returned.
    task automatic step(input bit r, input bit e, input logic [7:0] d,
                        input bit mr, input bit c,
                        output bit popped, output logic [7:0] exp_b,
                        output logic [7:0] got_b);
        bit push;
        bit ev;
        rx_ready = r;
        rx_error = e;
        rx_data  = d;
        m_ready  = mr;
        clear    = c;
        popped   = 0;
        exp_b    = 8'h00;
        got_b    = m_data;
        if (c) begin
            q.delete();
            m_ovf = 0;
            m_err = 0;
        end else begin
            push = r & ~p_r;
            ev   = e & ~p_e;
            if (mr && q.size() > 0) begin
                popped = 1;
                exp_b  = q.pop_front();
            end
            if (push) begin
                if (q.size() < DEPTH) q.push_back(d);
                else m_ovf = 1;
            end
            if (ev && m_err < 255) m_err++;
        end
        p_r = r;
        p_e = e;
        @(negedge clk50m);
    endtask

    task automatic test_reset();
        bit pp;
        logic [7:0] eb, gb;
        rst = 1'b1;
        rx_ready = 1'b1;
        rx_data = 8'h77;
        @(negedge clk50m);
        @(negedge clk50m);
        rst = 1'b0;
        q.delete();
        m_ovf = 0;
        m_err = 0;
        p_r = 1;
        p_e = 1;
        n_cmp++;
        if (level !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_level got %0d want 0", level);
        end
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid got %b want 0", m_valid);
        end
        n_cmp++;
        if ({full, overflow, err_cnt} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_flags got f=%b o=%b e=%0d want 0",
                     full, overflow, err_cnt);
        end
        repeat (4) step(1, 0, 8'h77, 0, 0, pp, eb, gb);
        n_cmp++;
        if (level !== 5'd0 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_held_flag got lvl=%0d v=%b want 0 0",
                     level, m_valid);
        end
        step(0, 0, 8'h00, 0, 0, pp, eb, gb);
    endtask

    task automatic test_single();
        bit pp;
        logic [7:0] eb, gb;
        step(1, 0, 8'hA5, 0, 0, pp, eb, gb);
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || level !== 5'd1) begin
            n_bad++;
            $display("FAIL single_push got v=%b d=%h l=%0d want 1 a5 1",
                     m_valid, m_data, level);
        end
        repeat (49) step(1, 0, 8'hA5, 0, 0, pp, eb, gb);
        n_cmp++;
        if (level !== 5'(q.size()) || level !== 5'd1) begin
            n_bad++;
            $display("FAIL single_hold got l=%0d want 1", level);
        end
        step(1, 0, 8'hA5, 1, 0, pp, eb, gb);
        n_cmp++;
        if (!pp || gb !== 8'hA5 || level !== 5'd0 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pop got d=%h l=%0d v=%b want a5 0 0",
                     gb, level, m_valid);
        end
        step(0, 0, 8'h00, 0, 0, pp, eb, gb);
    endtask

    task automatic test_fill_overflow();
        bit pp;
        logic [7:0] eb, gb;
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 8'(i), 0, 0, pp, eb, gb);
            step(0, 0, 8'h00, 0, 0, pp, eb, gb);
        end
        n_cmp++;
        if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL fill got f=%b l=%0d o=%b want 1 16 0",
                     full, level, overflow);
        end
        step(1, 0, 8'hFF, 0, 0, pp, eb, gb);
        step(0, 0, 8'h00, 0, 0, pp, eb, gb);
        n_cmp++;
        if (overflow !== 1'b1 || level !== 5'd16 || m_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow got o=%b l=%0d want 1 16",
                     overflow, level);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 8'h00, 1, 0, pp, eb, gb);
            n_cmp++;
            if (!pp || gb !== eb || gb !== 8'(i)) begin
                n_bad++;
                $display("FAIL fill_order[%0d] got %h want %h", i, gb, i);
            end
        end
        n_cmp++;
        if (m_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL drain got v=%b l=%0d o=%b want 0 0 1",
                     m_valid, level, overflow);
        end
        step(0, 0, 8'h00, 0, 0, pp, eb, gb);
    endtask

    task automatic test_full_push_pop();
        bit pp;
        logic [7:0] eb, gb;
        step(0, 0, 8'h00, 0, 1, pp, eb, gb);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 8'(8'h10 + i), 0, 0, pp, eb, gb);
            step(0, 0, 8'h00, 0, 0, pp, eb, gb);
        end
        step(1, 0, 8'h55, 1, 0, pp, eb, gb);
        n_cmp++;
        if (!pp || gb !== 8'h10) begin
            n_bad++;
            $display("FAIL pp_head got %h want 10", gb);
        end
        n_cmp++;
        if (level !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
            n_bad++;
            $display("FAIL pp_level got l=%0d o=%b f=%b want 16 0 1",
                     level, overflow, full);
        end
        step(0, 0, 8'h00, 0, 0, pp, eb, gb);
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(0, 0, 8'h00, 1, 0, pp, eb, gb);
            n_cmp++;
            if (!pp || gb !== eb) begin
                n_bad++;
                $display("FAIL pp_order[%0d] got %h want %h", i, gb, eb);
            end
        end
        step(0, 0, 8'h00, 1, 0, pp, eb, gb);
        n_cmp++;
        if (!pp || gb !== 8'h55 || level !== 5'd0) begin
            n_bad++;
            $display("FAIL pp_last got %h l=%0d want 55 0", gb, level);
        end
        step(0, 0, 8'h00, 0, 0, pp, eb, gb);
    endtask

    task automatic test_err_sat();
        bit pp;
        logic [7:0] eb, gb;
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 8'h00, 0, 0, pp, eb, gb);
            step(0, 0, 8'h00, 0, 0, pp, eb, gb);
            if (i == 99) begin
                n_cmp++;
                if (err_cnt !== 8'd100) begin
                    n_bad++;
                    $display("FAIL err_mid got %0d want 100", err_cnt);
                end
            end
        end
        n_cmp++;
        if (err_cnt !== 8'(m_err) || err_cnt !== 8'd255 || level !== 5'd0) begin
            n_bad++;
            $display("FAIL err_sat got %0d l=%0d want 255 0", err_cnt, level);
        end
        step(0, 0, 8'h00, 0, 1, pp, eb, gb);
        n_cmp++;
        if (err_cnt !== 8'd0 || overflow !== 1'b0 || level !== 5'd0) begin
            n_bad++;
            $display("FAIL clear got e=%0d o=%b l=%0d want 0 0 0",
                     err_cnt, overflow, level);
        end
        step(1, 1, 8'h3C, 0, 0, pp, eb, gb);
        n_cmp++;
        if (err_cnt !== 8'd1 || level !== 5'd1 || m_data !== 8'h3C) begin
            n_bad++;
            $display("FAIL push_and_err got e=%0d l=%0d d=%h want 1 1 3c",
                     err_cnt, level, m_data);
        end
        step(1, 1, 8'h00, 1, 1, pp, eb, gb);
        n_cmp++;
        if (err_cnt !== 8'd0 || level !== 5'd0 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_wins got e=%0d l=%0d v=%b want 0 0 0",
                     err_cnt, level, m_valid);
        end
        step(0, 0, 8'h00, 0, 0, pp, eb, gb);
    endtask

    task automatic test_stream();
        bit pp;
        logic [7:0] eb, gb;
        int sent = 0;
        int got = 0;
        int bad_lvl = 0;
        int budget = 0;
        bit e;
        while (sent < 1000 && budget < 40000) begin
            for (int k = 0; k < 20; k++) begin
                e = ($urandom_range(0, 7) == 0);
                if (k < 3)
                    step(1, e, 8'(sent), $urandom_range(0, 1) == 1, 0,
                         pp, eb, gb);
                else
                    step(0, e, 8'($urandom), $urandom_range(0, 1) == 1, 0,
                         pp, eb, gb);
                budget++;
                if (pp) begin
                    got++;
                    n_cmp++;
                    if (gb !== eb) begin
                        n_bad++;
                        $display("FAIL stream_data[%0d] got %h want %h",
                                 got, gb, eb);
                    end
                end
                if (level > 5'd16 || level !== 5'(q.size())) bad_lvl++;
            end
            sent++;
        end
        while (q.size() > 0 && budget < 40000) begin
            step(0, 0, 8'h00, 1, 0, pp, eb, gb);
            budget++;
            if (pp) begin
                got++;
                n_cmp++;
                if (gb !== eb) begin
                    n_bad++;
                    $display("FAIL stream_tail got %h want %h", gb, eb);
                end
            end
        end
        n_cmp++;
        if (got != 1000 || sent != 1000) begin
            n_bad++;
            $display("FAIL stream_count got %0d of %0d want 1000",
                     got, sent);
        end
        n_cmp++;
        if (bad_lvl != 0) begin
            n_bad++;
            $display("FAIL stream_level got %0d bad cycles want 0", bad_lvl);
        end
        n_cmp++;
        if (err_cnt !== 8'(m_err) || overflow !== m_ovf) begin
            n_bad++;
            $display("FAIL stream_stats got e=%0d o=%b want %0d %b",
                     err_cnt, overflow, m_err, m_ovf);
        end
    endtask

    initial begin
        @(negedge clk50m);
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_err_sat();
        test_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
